shift_sequencer: RTL

//  Multi-count shift/rotate unit for the 8088 core: executes ROL/ROR/RCL/RCR/SHL/SHR/SAR by an

---
 rtl/shift_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-count shift/rotate unit: executes ROL/ROR/RCL/RCR/SHL/SHR/SAR by an
// arbitrary count, one bit per CLKx4 cycle, with a start/busy/done handshake.
module shift_sequencer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned COUNT_W    = 8,
  parameter int unsigned MASK_COUNT = 0
) (
  input  logic               CLKx4,
  input  logic               RESETn,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [COUNT_W-1:0] Count,
  input  logic [2:0]         Operation,
  input  logic               byteWord,
  input  logic               carryIn,
  output logic               busy,
  output logic               done,
  output logic               flagsValid,
  output logic [WIDTH-1:0]   S,
  output logic               F_Overflow,
  output logic               F_Neg,
  output logic               F_Zero,
  output logic               F_Aux,
  output logic               F_Parity,
  output logic               F_Carry
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [WIDTH-1:0]   BYTE_MASK = WIDTH'(8'hFF);
  localparam logic [COUNT_W-1:0] CNT_MASK  =
    (MASK_COUNT != 0) ? COUNT_W'(5'h1F) : {COUNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   v_q;
  logic               c_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [2:0]         op_q;
  logic               bw_q;

  logic [COUNT_W-1:0] eff_cnt;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   nv;
  logic               nc, msb, msb1, nmsb, nmsb1, lin, rin, of_n, zf_n;

  // Effective count and operand as seen at acceptance (byte mode clears upper bits)
  always_comb begin
    eff_cnt = Count & CNT_MASK;
    a_sel   = byteWord ? A : (A & BYTE_MASK);
  end

  // One single-bit step on the latched working value; also derives final-step flags
  always_comb begin
    msb  = bw_q ? v_q[WIDTH-1] : v_q[7];
    msb1 = bw_q ? v_q[WIDTH-2] : v_q[6];
    case (op_q[2:1])
      2'b00:   lin = msb;
      2'b01:   lin = c_q;
      default: lin = 1'b0;
    endcase
    case (op_q[2:1])
      2'b00:   rin = v_q[0];
      2'b01:   rin = c_q;
      2'b10:   rin = 1'b0;
      default: rin = msb;
    endcase
    // Byte-mode right shifts rely on the upper bits being zero, so bit 7 of
    // v>>1 is free to receive the incoming bit.
    if (op_q[0]) begin
      nv = v_q >> 1;
      if (bw_q) nv[WIDTH-1] = rin;
      else      nv[7]       = rin;
      nc = v_q[0];
    end else begin
      nv    = v_q << 1;
      nv[0] = lin;
      if (!bw_q) nv = nv & BYTE_MASK;
      nc = msb;
    end
    nmsb  = bw_q ? nv[WIDTH-1] : nv[7];
    nmsb1 = bw_q ? nv[WIDTH-2] : nv[6];
    zf_n  = bw_q ? (nv == '0) : (nv[7:0] == 8'h00);
    case (op_q)
      3'b000, 3'b010: of_n = nmsb ^ nc;
      3'b001, 3'b011: of_n = nmsb ^ nmsb1;
      3'b100, 3'b110: of_n = msb ^ msb1;
      3'b101:         of_n = msb;
      default:        of_n = 1'b0;
    endcase
  end

  // Next-state logic and busy indication
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (eff_cnt != '0)) state_d = SHIFT;
      SHIFT:   if (cnt_q == COUNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy = (state_q == SHIFT);
  end

  // State register
  always_ff @(posedge CLKx4 or negedge RESETn) begin
    if (!RESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath: latch on acceptance, step while shifting, publish result on last step
  always_ff @(posedge CLKx4 or negedge RESETn) begin
    if (!RESETn) begin
      v_q        <= '0;
      c_q        <= 1'b0;
      cnt_q      <= '0;
      op_q       <= '0;
      bw_q       <= 1'b0;
      done       <= 1'b0;
      flagsValid <= 1'b0;
      S          <= '0;
      F_Overflow <= 1'b0;
      F_Neg      <= 1'b0;
      F_Zero     <= 1'b0;
      F_Aux      <= 1'b0;
      F_Parity   <= 1'b0;
      F_Carry    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (eff_cnt == '0) begin
              done       <= 1'b1;
              flagsValid <= 1'b0;
              S          <= a_sel;
            end else begin
              v_q   <= a_sel;
              c_q   <= carryIn;
              cnt_q <= eff_cnt;
              op_q  <= Operation;
              bw_q  <= byteWord;
            end
          end
        end
        SHIFT: begin
          v_q   <= nv;
          c_q   <= nc;
          cnt_q <= cnt_q - COUNT_W'(1);
          if (cnt_q == COUNT_W'(1)) begin
            done       <= 1'b1;
            flagsValid <= 1'b1;
            S          <= nv;
            F_Carry    <= nc;
            F_Neg      <= nmsb;
            F_Zero     <= zf_n;
            F_Aux      <= nv[4];
            F_Parity   <= ~^nv[7:0];
            F_Overflow <= of_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
